fetch_stage: RTL
================

# fetch_stage

Instruction-fetch stage of the 4-bit-opcode pipelined RISC core, sitting directly upstream of the decode/control unit. It owns the PC, issues word fetches to instruction memory over a request/acknowledge handshake, and holds the IF/ID pipeline register whose opcode field drives the control decoder. It honours stalls from the hazard unit, redirects from decode (`pcsrc1`) and execute (`pcsrc2`), and the `IF_ID_Flush` produced by control, which it applies by inserting NOPs.

## Interface
- `PC_W`, 16: PC and instruction-memory word-address width.
- `INSTR_W`, 16: instruction width; opcode is bits `[INSTR_W-1:INSTR_W-4]`.
- `RESET_PC`, 0: PC value after reset.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `stall` in 1: hazard unit holds the PC and IF/ID.
- `pcsrc1` in 1: decode-stage redirect (jump).
- `target1` in PC_W: redirect address for `pcsrc1`.
- `pcsrc2` in 1: execute-stage redirect (branch taken).
- `target2` in PC_W: redirect address for `pcsrc2`.
- `if_id_flush` in 1: from control; squashes IF/ID.
- `imem_req` out 1: fetch request.
- `imem_addr` out PC_W: fetch word address; stable while `imem_req` is high until ack.
- `imem_ack` in 1: read data valid this cycle; may be asserted in the request cycle.
- `imem_rdata` in INSTR_W: instruction word.
- `if_id_instr` out INSTR_W: instruction to decode.
- `if_id_pc1` out PC_W: address of that instruction + 1.
- `if_id_valid` out 1: IF/ID holds a real instruction.

## Operation
- NOP is all-zero; opcode 0000 decodes to no writes and no branches.
- FSM states: `BOOT`, `FETCH`, `HOLD`, `DISCARD`.
- `BOOT`: entered on reset. `imem_req`=0. Moves to `FETCH` after one cycle.
- `FETCH`: `imem_req`=1, `imem_addr`=pc.
  - Ack with no stall and no redirect: IF/ID <= {rdata, pc+1, valid=1}; pc <= pc+1.
  - Ack with stall: rdata goes to the skid buffer; go to `HOLD`.
  - Redirect with ack: data dropped; pc <= target; stay in `FETCH`.
  - Redirect without ack: pc <= target; go to `DISCARD`.
- `HOLD`: `imem_req`=0.
  - Stall drops: IF/ID <= buffer; pc <= pc+1; go to `FETCH`.
  - Redirect: buffer dropped; pc <= target; go to `FETCH`.
- `DISCARD`: re-issues the stale address captured at redirect, since the address must stay stable until ack.
  - Ack: data dropped; go to `FETCH`, which then fetches the new pc.
  - Further redirect: pc updates; stay in `DISCARD`.
- Redirect priority: `pcsrc2` beats `pcsrc1` (older instruction).
- IF/ID update priority: `if_id_flush` > `stall` (hold) > new capture. Flush loads NOP with valid=0, even while stalled.
- PC arithmetic is modulo 2^PC_W: 0xFFFF+1 = 0x0000 at PC_W=16.
- Reset mid-fetch abandons any outstanding request. The memory must tolerate `imem_req` dropping without an ack under reset.

## Timing
- Reset values:
  - pc=`RESET_PC`, state=`BOOT`.
  - `imem_req`=0, `imem_addr`=`RESET_PC`.
  - `if_id_instr`=0, `if_id_pc1`=0, `if_id_valid`=0.
- With a zero-wait memory (ack in the request cycle), throughput is 1 instruction/cycle. An instruction appears on `if_id_instr` the edge after its ack.
- Redirect sampled at edge N: `imem_addr`=target from cycle N+1, except in `DISCARD`, where it follows the stale ack.
- Stall release: the buffered instruction appears in IF/ID one edge later, with no refetch.
- All outputs are registered or decoded from state; no combinational path from `imem_rdata` to any output.

## Configuration
- `FETCH_PERF_EN` defined:
  - Adds outputs `perf_fetched` (32) and `perf_squashed` (32), reset to 0, saturating at 0xFFFFFFFF.
  - `perf_fetched` increments on each instruction entering IF/ID with valid=1.
  - `perf_squashed` increments on each acked word dropped by a redirect or flush, or by `DISCARD`.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

## Structure
- Shared package `risc_pkg` holds:
  - `OPCODE_W`=4.
  - `NOP_INSTR`.
  - The fetch FSM state enum.
  - The default `PC_W` and `INSTR_W`.
- Sub-module `if_id_reg`: IF/ID register with flush/stall priority and async reset. The FSM, PC and skid buffer stay in `fetch_stage`.

## Test plan
- Reset release, zero-wait memory returning addr+0x100: `imem_addr` sequence 0,1,2…; `if_id_instr` 0x100,0x101…; `if_id_pc1` 1,2,…; valid rises at the 2nd edge after `BOOT`.
- Stall for 3 cycles coincident with the ack of addr 5: `imem_req` low in `HOLD`; IF/ID holds instruction 4; after release, instruction 5 enters IF/ID with no re-request of addr 5.
- 2-wait-state memory, `pcsrc2` with target2=0x40 one cycle after the request to addr 7: `imem_addr` stays 7 until ack; that data is dropped; next request is 0x40.
- `pcsrc1` (target1=0x20) and `pcsrc2` (target2=0x30) in the same cycle: next fetch address is 0x30.
- `if_id_flush` together with `stall`: IF/ID becomes 0x0000 with valid=0.
- PC at 0xFFFF, zero-wait memory: next `imem_addr`=0x0000, and `if_id_pc1`=0x0000 for the 0xFFFF instruction.

Source files
------------

// File: rtl/risc_pkg.sv
// risc_pkg: shared constants and types for the 4-bit-opcode RISC pipeline.
// Holds opcode width, NOP encoding, default widths and the fetch FSM enum.
package risc_pkg;

  localparam int OPCODE_W    = 4;
  localparam int DEF_PC_W    = 16;
  localparam int DEF_INSTR_W = 16;

  localparam logic [DEF_INSTR_W-1:0] NOP_INSTR = '0;

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    HOLD,
    DISCARD
  } fetchState_t;

  function automatic logic [31:0] satInc(
    input logic [31:0] v
  );
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory request/acknowledge bus.
// master = fetch stage, slave = instruction memory.
interface fetch_stage_if import risc_pkg::*; #(
  parameter int PC_W    = DEF_PC_W,
  parameter int INSTR_W = DEF_INSTR_W
);

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register.
// Priority: flush (NOP, invalid) > stall (hold) > load; no load leaves a bubble.
module if_id_reg import risc_pkg::*; #(
  parameter int PC_W    = DEF_PC_W,
  parameter int INSTR_W = DEF_INSTR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               stall,
  input  logic               load,
  input  logic [INSTR_W-1:0] instrIn,
  input  logic [PC_W-1:0]    pc1In,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    pc1,
  output logic               valid
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr <= INSTR_W'(NOP_INSTR);
      pc1   <= '0;
      valid <= 1'b0;
    end else if (flush) begin
      instr <= INSTR_W'(NOP_INSTR);
      pc1   <= '0;
      valid <= 1'b0;
    end else if (!stall) begin
      instr <= load ? instrIn : INSTR_W'(NOP_INSTR);
      pc1   <= load ? pc1In : '0;
      valid <= load;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, fetch FSM and skid buffer feeding the IF/ID register.
// Define FETCH_PERF_EN to add the perf_fetched/perf_squashed counters.
module fetch_stage import risc_pkg::*; #(
  parameter int              PC_W     = DEF_PC_W,
  parameter int              INSTR_W  = DEF_INSTR_W,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               pcsrc1,
  input  logic [PC_W-1:0]    target1,
  input  logic               pcsrc2,
  input  logic [PC_W-1:0]    target2,
  input  logic               if_id_flush,
  fetch_stage_if.master      imem,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [PC_W-1:0]    if_id_pc1,
  output logic               if_id_valid
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_squashed
`endif
);

  fetchState_t        state;
  fetchState_t        nextState;
  logic [PC_W-1:0]    pc;
  logic [PC_W-1:0]    pcNext;
  logic [PC_W-1:0]    pcInc;
  logic [PC_W-1:0]    staleAddr;
  logic [PC_W-1:0]    staleNext;
  logic [INSTR_W-1:0] skid;
  logic [INSTR_W-1:0] skidNext;
  logic [INSTR_W-1:0] loadInstr;
  logic               load;
  logic               redir;
  logic [PC_W-1:0]    target;

  // execute-stage redirect is older, so it wins
  assign redir  = pcsrc1 | pcsrc2;
  assign target = pcsrc2 ? target2 : target1;
  assign pcInc  = pc + PC_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= BOOT;
      pc        <= RESET_PC;
      staleAddr <= RESET_PC;
      skid      <= INSTR_W'(NOP_INSTR);
    end else begin
      state     <= nextState;
      pc        <= pcNext;
      staleAddr <= staleNext;
      skid      <= skidNext;
    end
  end

  always_comb begin
    nextState = state;
    pcNext    = pc;
    staleNext = staleAddr;
    skidNext  = skid;
    load      = 1'b0;
    loadInstr = imem.imem_rdata;
    unique case (state)
      BOOT: begin
        nextState = FETCH;
        if (redir) pcNext = target;
      end
      FETCH: begin
        if (redir) begin
          pcNext = target;
          // unacked request must be completed at its old address
          if (!imem.imem_ack) begin
            staleNext = pc;
            nextState = DISCARD;
          end
        end else if (imem.imem_ack) begin
          if (stall) begin
            skidNext  = imem.imem_rdata;
            nextState = HOLD;
          end else begin
            load   = 1'b1;
            pcNext = pcInc;
          end
        end
      end
      HOLD: begin
        loadInstr = skid;
        if (redir) begin
          pcNext    = target;
          nextState = FETCH;
        end else if (!stall) begin
          load      = 1'b1;
          pcNext    = pcInc;
          nextState = FETCH;
        end
      end
      DISCARD: begin
        if (redir) pcNext = target;
        if (imem.imem_ack) nextState = FETCH;
      end
      default: nextState = BOOT;
    endcase
  end

  always_comb begin
    imem.imem_req  = 1'b0;
    imem.imem_addr = pc;
    unique case (state)
      FETCH: imem.imem_req = 1'b1;
      DISCARD: begin
        imem.imem_req  = 1'b1;
        imem.imem_addr = staleAddr;
      end
      default: imem.imem_req = 1'b0;
    endcase
  end

  if_id_reg #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_if_id (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (if_id_flush),
    .stall   (stall),
    .load    (load),
    .instrIn (loadInstr),
    .pc1In   (pcInc),
    .instr   (if_id_instr),
    .pc1     (if_id_pc1),
    .valid   (if_id_valid)
  );

`ifdef FETCH_PERF_EN
  logic dropped;

  assign dropped =
    (state == FETCH && redir && imem.imem_ack) ||
    (state == HOLD && redir) ||
    (state == DISCARD && imem.imem_ack) ||
    (load && if_id_flush);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched  <= '0;
      perf_squashed <= '0;
    end else begin
      if (load && !if_id_flush)
        perf_fetched <= satInc(perf_fetched);
      if (dropped)
        perf_squashed <= satInc(perf_squashed);
    end
  end
`endif

endmodule
